// File: rtl/serial_addsub.sv
// Bit-serial LSB-first add/sub of A with CONST or B; one-cycle registered result stream.
// Stall by dropping in_valid (state holds); flush aborts the open word; no ready backpressure.
module serial_addsub #(
  parameter int unsigned           WIDTH = 4,
  parameter logic [WIDTH-1:0]      CONST = 4'b0011
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic in_valid,
  input  logic in_a,
  input  logic in_b,
  input  logic sel_const,
  input  logic sub,
  output logic out_valid,
  output logic out_bit,
  output logic out_last,
  output logic carry_out,
  output logic ovf
);

  localparam int unsigned IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             m_sel_q, m_sel_d;
  logic             m_sub_q, m_sub_d;
  logic             out_valid_q, out_valid_d;
  logic             out_bit_q, out_bit_d;
  logic             out_last_q, out_last_d;
  logic             carry_out_q, carry_out_d;
  logic             ovf_q, ovf_d;

  logic vld, last, sel_w, sub_w, c_in, add_bit, sum_bit, c_next;

  always_comb begin
    vld  = in_valid && !flush;
    last = (idx_q == IDX_W'(WIDTH - 1));
    // Bit 0 takes the live mode and seeds carry with sub (two's-complement +1).
    sel_w   = (state_q == IDLE) ? sel_const : m_sel_q;
    sub_w   = (state_q == IDLE) ? sub       : m_sub_q;
    c_in    = (state_q == IDLE) ? sub       : carry_q;
    add_bit = (sel_w ? CONST[idx_q] : in_b) ^ sub_w;
    sum_bit = in_a ^ add_bit ^ c_in;
    c_next  = (in_a & add_bit) | (in_a & c_in) | (add_bit & c_in);
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    m_sel_d     = m_sel_q;
    m_sub_d     = m_sub_q;
    out_valid_d = vld;
    out_bit_d   = vld & sum_bit;
    out_last_d  = vld & last;
    carry_out_d = carry_out_q;
    ovf_d       = ovf_q;

    if (flush) begin
      state_d = IDLE;
      idx_d   = '0;
      carry_d = 1'b0;
    end else if (in_valid) begin
      if (state_q == IDLE) begin
        m_sel_d = sel_const;
        m_sub_d = sub;
      end
      if (last) begin
        state_d     = IDLE;
        idx_d       = '0;
        carry_d     = 1'b0;
        carry_out_d = c_next;
        ovf_d       = c_in ^ c_next;
      end else begin
        state_d = RUN;
        idx_d   = idx_q + 1'b1;
        carry_d = c_next;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      m_sel_q     <= 1'b0;
      m_sub_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      out_last_q  <= 1'b0;
      carry_out_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      m_sel_q     <= m_sel_d;
      m_sub_q     <= m_sub_d;
      out_valid_q <= out_valid_d;
      out_bit_q   <= out_bit_d;
      out_last_q  <= out_last_d;
      carry_out_q <= carry_out_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_bit   = out_bit_q;
  assign out_last  = out_last_q;
  assign carry_out = carry_out_q;
  assign ovf       = ovf_q;

endmodule
